// File: rtl/fence_flush_seq.sv
// Memory-ordering sequencer for FENCE / FENCE.I / SFENCE.VMA.
// Optional watchdog on the DRAIN/SYNCH waits: define FENCE_TIMEOUT_EN.
package fence_flush_pkg;
  typedef logic [15:0] asid_t;
  typedef logic [26:0] vpn_t;
  typedef enum logic [1:0] {
    NoFlush,
    FlushAll,
    FlushASID,
    FlushPage
  } tlb_flush_e;
endpackage

module fence_flush_seq
  import fence_flush_pkg::*;
#(
  parameter int MSHR_CLR_CYCLES = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [1:0] req_type_i,
  input  logic       rs1_zero_i,
  input  logic       rs2_zero_i,
  input  asid_t      asid_i,
  input  vpn_t       vpn_i,
  input  logic       abort_i,
  input  logic       lsq_empty_i,
  input  logic       l2c_update_done_i,
  output logic       stall_o,
  output logic       synch_l1dc_l2c_o,
  output logic       clr_l1tlb_mshr_o,
  output logic       clr_l2tlb_mshr_o,
  output logic       clear_dmshr_dregs_o,
  output logic       icache_flush_o,
  output tlb_flush_e L1TLB_flush_type_o,
  output tlb_flush_e L2TLB_flush_type_o,
  output asid_t      flush_asid_o,
  output vpn_t       flush_page_o,
  output logic       done_o,
  output logic       timeout_o
);

  localparam int CW = (MSHR_CLR_CYCLES > 1) ?
                      $clog2(MSHR_CLR_CYCLES) : 1;

  localparam logic [1:0] K_FENCE  = 2'd0;
  localparam logic [1:0] K_FENCEI = 2'd1;
  localparam logic [1:0] K_SFENCE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_SYNCH,
    S_CLR,
    S_TLB,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    kind_q;
  logic          rs1z_q, rs2z_q;
  asid_t         asid_q;
  vpn_t          vpn_q;
  logic [CW-1:0] clr_cnt_q;
  logic          accept;
  logic          wd_hit;

  assign accept = (state_q == S_IDLE) &&
                  req_valid_i && !abort_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reserved type 3 collapses to a plain FENCE at accept time.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      kind_q <= K_FENCE;
      rs1z_q <= 1'b0;
      rs2z_q <= 1'b0;
      asid_q <= '0;
      vpn_q  <= '0;
    end else if (accept) begin
      kind_q <= (req_type_i == 2'd3) ? K_FENCE : req_type_i;
      rs1z_q <= rs1_zero_i;
      rs2z_q <= rs2_zero_i;
      asid_q <= asid_i;
      vpn_q  <= vpn_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clr_cnt_q <= '0;
    end else if (abort_i) begin
      clr_cnt_q <= '0;
    end else if (state_q == S_SYNCH && state_d == S_CLR) begin
      clr_cnt_q <= CW'(MSHR_CLR_CYCLES - 1);
    end else if (state_q == S_CLR && clr_cnt_q != '0) begin
      clr_cnt_q <= clr_cnt_q - 1'b1;
    end
  end

`ifdef FENCE_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wd_q;
  logic          in_wait;

  assign in_wait = (state_q == S_DRAIN) || (state_q == S_SYNCH);
  assign wd_hit  = in_wait && (wd_q == WW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wd_q <= '0;
    end else if (abort_i || state_d != state_q) begin
      wd_q <= '0;
    end else if (in_wait) begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_valid_i) state_d = S_DRAIN;
      S_DRAIN: if (lsq_empty_i) state_d = S_SYNCH;
      S_SYNCH: begin
        if (l2c_update_done_i) begin
          state_d = (kind_q == K_FENCE) ? S_DONE : S_CLR;
        end
      end
      S_CLR: begin
        if (kind_q == K_FENCEI) begin
          state_d = S_DONE;
        end else if (clr_cnt_q == '0) begin
          state_d = S_TLB;
        end
      end
      S_TLB:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (wd_hit) state_d = S_IDLE;
    if (abort_i) state_d = S_IDLE;
  end

  always_comb begin
    req_ready_o         = 1'b0;
    stall_o             = 1'b0;
    synch_l1dc_l2c_o    = 1'b0;
    clr_l1tlb_mshr_o    = 1'b0;
    clr_l2tlb_mshr_o    = 1'b0;
    clear_dmshr_dregs_o = 1'b0;
    icache_flush_o      = 1'b0;
    L1TLB_flush_type_o  = NoFlush;
    L2TLB_flush_type_o  = NoFlush;
    flush_asid_o        = '0;
    flush_page_o        = '0;
    done_o              = 1'b0;
    timeout_o           = 1'b0;
    unique case (state_q)
      S_IDLE:  req_ready_o = !abort_i;
      S_DRAIN: stall_o = 1'b1;
      S_SYNCH: begin
        stall_o          = 1'b1;
        synch_l1dc_l2c_o = 1'b1;
      end
      S_CLR: begin
        stall_o = 1'b1;
        if (kind_q == K_SFENCE) begin
          clr_l1tlb_mshr_o    = 1'b1;
          clr_l2tlb_mshr_o    = 1'b1;
          clear_dmshr_dregs_o = 1'b1;
        end else begin
          icache_flush_o = 1'b1;
        end
      end
      S_TLB: begin
        stall_o = 1'b1;
        if (rs1z_q && rs2z_q) begin
          L1TLB_flush_type_o = FlushAll;
        end else if (rs1z_q) begin
          L1TLB_flush_type_o = FlushASID;
          flush_asid_o       = asid_q;
        end else begin
          L1TLB_flush_type_o = FlushPage;
          flush_page_o       = vpn_q;
          flush_asid_o       = rs2z_q ? '0 : asid_q;
        end
        L2TLB_flush_type_o = L1TLB_flush_type_o;
      end
      S_DONE: begin
        stall_o = 1'b1;
        done_o  = !abort_i;
      end
      default: stall_o = 1'b0;
    endcase
    // A watchdog expiry ends the sequence as a (failed) completion.
    if (wd_hit) begin
      timeout_o = !abort_i;
      done_o    = !abort_i;
    end
  end

endmodule

// File: tb/tb_fence_flush_seq.sv
// Randomized self-checking bench for fence_flush_seq.
// Expected outputs come from a per-transaction timeline model.
module tb_fence_flush_seq;
  import fence_flush_pkg::*;

  localparam int M  = 2;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_type;
  logic       rs1z, rs2z;
  asid_t      asid;
  vpn_t       vpn;
  logic       abort_r;
  logic       lsq_empty;
  logic       l2c_done;
  logic       stall, synch, c1, c2, cd, icf;
  tlb_flush_e f1, f2;
  asid_t      f_asid;
  vpn_t       f_page;
  logic       done, tmo;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fence_flush_seq #(
    .MSHR_CLR_CYCLES(M),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_type_i         (req_type),
    .rs1_zero_i         (rs1z),
    .rs2_zero_i         (rs2z),
    .asid_i             (asid),
    .vpn_i              (vpn),
    .abort_i            (abort_r),
    .lsq_empty_i        (lsq_empty),
    .l2c_update_done_i  (l2c_done),
    .stall_o            (stall),
    .synch_l1dc_l2c_o   (synch),
    .clr_l1tlb_mshr_o   (c1),
    .clr_l2tlb_mshr_o   (c2),
    .clear_dmshr_dregs_o(cd),
    .icache_flush_o     (icf),
    .L1TLB_flush_type_o (f1),
    .L2TLB_flush_type_o (f2),
    .flush_asid_o       (f_asid),
    .flush_page_o       (f_page),
    .done_o             (done),
    .timeout_o          (tmo)
  );

  typedef struct packed {
    logic       rdy;
    logic       stall;
    logic       synch;
    logic       c1;
    logic       c2;
    logic       cd;
    logic       icf;
    tlb_flush_e f1;
    tlb_flush_e f2;
    asid_t      asid;
    vpn_t       page;
    logic       done;
    logic       tmo;
  } obs_t;

  function automatic obs_t grab();
    obs_t o;
    o.rdy   = req_ready;
    o.stall = stall;
    o.synch = synch;
    o.c1    = c1;
    o.c2    = c2;
    o.cd    = cd;
    o.icf   = icf;
    o.f1    = f1;
    o.f2    = f2;
    o.asid  = f_asid;
    o.page  = f_page;
    o.done  = done;
    o.tmo   = tmo;
    return o;
  endfunction

  task automatic check(input string tag, input int t, input obs_t e);
    obs_t o;
    o = grab();
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, o, e);
    end
  endtask

  function automatic obs_t idle_exp(input logic ab);
    obs_t e;
    e = '0;
    e.rdy = !ab;
    return e;
  endfunction

  // Cycle (relative to accept) at which done_o fires.
  function automatic int done_at(input int k, input int dw, input int sw);
    int se;
    se = dw + 2 + sw;
    if (k == 1) return se + 2;
    if (k == 2) return se + M + 2;
    return se + 1;
  endfunction

  // lsq_empty low for cycles 1..dw, l2c_done low for the first sw SYNCH cycles.
  function automatic obs_t model(input int k, input logic r1, input logic r2,
                                 input asid_t a, input vpn_t v,
                                 input int dw, input int sw, input int t);
    obs_t e;
    int   ss, se, dn;
    e  = '0;
    ss = dw + 2;
    se = ss + sw;
    dn = done_at(k, dw, sw);
    e.rdy   = (t == 0);
    e.stall = (t >= 1) && (t <= dn);
    e.synch = (t >= ss) && (t <= se);
    e.icf   = (k == 1) && (t == se + 1);
    if (k == 2 && t > se && t <= se + M) begin
      e.c1 = 1'b1;
      e.c2 = 1'b1;
      e.cd = 1'b1;
    end
    if (k == 2 && t == se + M + 1) begin
      if (r1 && r2) begin
        e.f1 = FlushAll;
      end else if (r1) begin
        e.f1   = FlushASID;
        e.asid = a;
      end else begin
        e.f1   = FlushPage;
        e.page = v;
        e.asid = r2 ? '0 : a;
      end
      e.f2 = e.f1;
    end
    e.done = (t == dn);
    return e;
  endfunction

  task automatic run_txn(input string tag, input logic [1:0] ty,
                         input logic r1, input logic r2,
                         input asid_t a, input vpn_t v,
                         input int dw, input int sw,
                         input int ab_at, input int rst_at);
    int k, ss, se, last;
    k    = (ty == 2'd3) ? 0 : int'(ty);
    ss   = dw + 2;
    se   = ss + sw;
    last = (ab_at > 0) ? ab_at : done_at(k, dw, sw);
    for (int t = 0; t <= last; t++) begin
      @(posedge clk);
      #1;
      if (t == 0) begin
        req_valid = 1'b1;
        req_type  = ty;
        rs1z      = r1;
        rs2z      = r2;
        asid      = a;
        vpn       = v;
        abort_r   = 1'b0;
      end else begin
        req_valid = 1'($urandom);
        req_type  = 2'($urandom);
        rs1z      = 1'($urandom);
        rs2z      = 1'($urandom);
        asid      = asid_t'($urandom);
        vpn       = vpn_t'($urandom);
        abort_r   = (t == ab_at);
      end
      if (t >= 1 && t <= dw) lsq_empty = 1'b0;
      else if (t == dw + 1)  lsq_empty = 1'b1;
      else                   lsq_empty = 1'($urandom);
      if (t >= ss && t < se) l2c_done = 1'b0;
      else if (t == se)      l2c_done = 1'b1;
      else                   l2c_done = 1'($urandom);
      @(negedge clk);
      check(tag, t, model(k, r1, r2, a, v, dw, sw, t));
      if (t == rst_at) begin
        req_valid = 1'b0;
        abort_r   = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("reset_mid", t, idle_exp(1'b0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
    end
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      req_valid = 1'($urandom);
      abort_r   = req_valid ? 1'b1 : 1'($urandom);
      req_type  = 2'($urandom);
      lsq_empty = 1'($urandom);
      l2c_done  = 1'($urandom);
      @(negedge clk);
      check("idle", i, idle_exp(abort_r));
    end
  endtask

  initial begin
    int    dw, sw, ab, dn, k;
    logic [1:0] ty;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_type  = 2'd0;
    rs1z      = 1'b0;
    rs2z      = 1'b0;
    asid      = '0;
    vpn       = '0;
    abort_r   = 1'b0;
    lsq_empty = 1'b1;
    l2c_done  = 1'b1;

    #12 check("reset", 0, idle_exp(1'b0));
    abort_r = 1'b1;
    #1 check("reset_abort", 0, idle_exp(1'b1));
    abort_r = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_txn("fence", 2'd0, 1'b0, 1'b0, '0, '0, 0, 0, -1, -1);
    run_txn("sfence_asid", 2'd2, 1'b1, 1'b0, 16'd5, '0, 0, 0, -1, -1);
    run_txn("sfence_page", 2'd2, 1'b0, 1'b1, 16'hbeef, 27'h123, 0, 0, -1, -1);
    run_txn("sfence_all", 2'd2, 1'b1, 1'b1, 16'h77, 27'h55, 0, 0, -1, -1);
    run_txn("sfence_pg_asid", 2'd2, 1'b0, 1'b0, 16'h9, 27'h7ff, 1, 1, -1, -1);
    run_txn("fence_i", 2'd1, 1'b0, 1'b0, '0, '0, 0, 0, -1, -1);
    run_txn("rsvd", 2'd3, 1'b1, 1'b1, 16'h3, 27'h3, 0, 2, -1, -1);
    idle_gap(3);
    run_txn("waits", 2'd0, 1'b0, 1'b0, '0, '0, 10, 7, -1, -1);
    run_txn("abort_synch", 2'd0, 1'b0, 1'b0, '0, '0, 2, 5, 6, -1);
    run_txn("after_abort", 2'd2, 1'b1, 1'b0, 16'h42, '0, 0, 0, -1, -1);
    run_txn("rst_mid", 2'd2, 1'b0, 1'b0, 16'h11, 27'h22, 1, 1, -1, 5);
    run_txn("after_rst", 2'd1, 1'b0, 1'b0, '0, '0, 0, 1, -1, -1);

`ifdef FENCE_TIMEOUT_EN
    for (int t = 0; t <= TO + 1; t++) begin
      obs_t e;
      @(posedge clk);
      #1;
      req_valid = (t == 0) ? 1'b1 : 1'($urandom);
      req_type  = 2'd2;
      rs1z      = 1'b1;
      rs2z      = 1'b1;
      abort_r   = 1'b0;
      lsq_empty = (t == 0);
      l2c_done  = 1'($urandom);
      @(negedge clk);
      e       = '0;
      e.rdy   = (t == 0);
      e.stall = (t >= 1);
      e.done  = (t == TO + 1);
      e.tmo   = (t == TO + 1);
      check("timeout", t, e);
    end
`endif

    for (int i = 0; i < 40; i++) begin
      ty = 2'($urandom_range(0, 3));
      k  = (ty == 2'd3) ? 0 : int'(ty);
      dw = $urandom_range(0, 12);
      sw = $urandom_range(0, 12);
      dn = done_at(k, dw, sw);
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, dn - 1) : -1;
      run_txn("rand", ty, 1'($urandom), 1'($urandom),
              asid_t'($urandom), vpn_t'($urandom), dw, sw, ab,
              ($urandom_range(0, 9) == 0 && ab < 0) ? $urandom_range(1, dn) : -1);
      if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 3));
    end

    idle_gap(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
